// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES-128 core among NUM_REQ requesters.
// Grants one job, pulses core_start, waits for done or timeout, returns result.
module aes_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_block,
  input  logic [NUM_REQ*128-1:0]   req_key,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [127:0]             rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     core_start,
  output logic [127:0]             core_block,
  output logic [127:0]             core_key,
  input  logic                     core_done,
  input  logic [127:0]             core_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic            found;
  logic            armed;
  logic            take;
  logic            timeout_hit;
  logic [TW-1:0]   timer;
  logic [127:0]    blk_q;
  logic [127:0]    key_q;
  logic [127:0]    data_q;
  logic            err_q;
  logic [127:0]    blk_arr [NUM_REQ];
  logic [127:0]    key_arr [NUM_REQ];

  function automatic logic [IW-1:0] ridx(
    input logic [IW-1:0] base,
    input int            k
  );
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign blk_arr[g] = req_block[g*128 +: 128];
    assign key_arr[g] = req_key[g*128 +: 128];
  end

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[ridx(rr_ptr, k)]) begin
        found = 1'b1;
        pick  = ridx(rr_ptr, k);
      end
    end
  end

  // armed holds grants off until the first edge after reset release.
  assign take        = (state_q == IDLE) && armed && found;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready[gnt]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed  <= 1'b0;
      gnt    <= '0;
      rr_ptr <= '0;
      timer  <= '0;
      blk_q  <= '0;
      key_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            gnt   <= pick;
            blk_q <= blk_arr[pick];
            key_q <= key_arr[pick];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          // done wins over a simultaneous timeout
          if (core_done) begin
            data_q <= core_result;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rr_ptr <= ridx(gnt, 1);
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (take) req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gnt] = 1'b1;
  end

  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);
  assign core_start = (state_q == ISSUE);
  assign core_block = blk_q;
  assign core_key   = key_q;

  a_req_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_no_overlap: assert property (
    @(posedge clk) disable iff (rst) !(|req_ready && |rsp_valid));

endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Round-robin scheduler that shares a single AES-128 encryption core between `NUM_REQ` independent requesters. Each requester presents a 128-bit plaintext block and 128-bit key; the arbiter grants one job at a time and launches the core with a one-cycle start pulse. It waits for the core's done pulse, with a timeout watchdog, and returns the ciphertext to the granted requester over a valid/ready response channel. It sits between the client ports and the `enc_aes` core wrapper, which exposes a start/done handshake.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max WAIT cycles before the job is aborted with error (≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a job pending; held until accepted
- `req_ready`  out  NUM_REQ  one-hot accept; `req_valid[i] & req_ready[i]` = job i taken
- `req_block`  in  NUM_REQ*128  plaintext, requester i at `[i*128 +: 128]`
- `req_key`  in  NUM_REQ*128  key, requester i at `[i*128 +: 128]`
- `rsp_valid`  out  NUM_REQ  one-hot response valid to granted requester
- `rsp_ready`  in  NUM_REQ  requester i accepts response
- `rsp_data`  out  128  ciphertext, or 0 on error; shared across requesters
- `rsp_err`  out  1  response is a timeout abort
- `busy`  out  1  state ≠ IDLE
- `core_start`  out  1  one-cycle launch pulse to core
- `core_block`  out  128  plaintext to core; stable from ISSUE until return to IDLE
- `core_key`  out  128  key to core; stable likewise
- `core_done`  in  1  core result valid pulse
- `core_result`  in  128  core ciphertext, valid when `core_done`=1

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Internal: `gnt` (index), `rr_ptr` (index), `timer` (clog2(TIMEOUT) bits), capture registers for block and key.
- IDLE:
  - Grant = first i with `req_valid[i]`=1, searching `rr_ptr, rr_ptr+1, …` mod NUM_REQ.
  - `req_ready` = one-hot grant, combinational, IDLE only; it is 0 when no request is pending.
  - On the grant edge: latch `req_block`/`req_key` of the winner into the capture registers, set `gnt`, go to ISSUE.
- ISSUE: `core_start`=1 for exactly this cycle; clear `timer`; go to WAIT.
- WAIT:
  - `core_done`=1: latch `core_result` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Else, `timer`==TIMEOUT-1: set `rsp_data`=0, `rsp_err`=1, go to RESP.
  - Else `timer`++.
  - `core_done` and timeout in the same cycle: done wins.
- RESP:
  - `rsp_valid[gnt]`=1; all other `rsp_valid` bits 0.
  - On `rsp_ready[gnt]`: go to IDLE, set `rr_ptr` = (gnt+1) mod NUM_REQ, clear `rsp_err`.
  - `rsp_ready` bits of non-granted requesters are ignored.
- `core_done` outside WAIT (including the ISSUE cycle) is ignored.
- Requester request lines are not sampled outside IDLE. New requests wait; there is no queueing.
- `rr_ptr` wrap: NUM_REQ-1 → 0.

## Timing
- Reset (async assert):
  - state IDLE, `rr_ptr`=0, `gnt`=0, `timer`=0.
  - `req_ready`=0 until the first edge after deassert, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `core_start`=0, `core_block`=0, `core_key`=0, `busy`=0.
- Reset mid-job aborts immediately. No response is issued and the core is not relaunched. A stale `core_done` arriving afterwards is ignored (state is IDLE).
- Accept at edge t → `core_start` high in cycle t+1 → WAIT begins at t+2.
- `core_done` in WAIT cycle t+2+d → `rsp_valid` from t+3+d.
- Timeout: no done in WAIT → `rsp_valid`, `rsp_err` from t+2+TIMEOUT.
- Response accepted at edge r → IDLE in cycle r+1; the next grant can occur in that cycle.
- Minimum job spacing is 4 cycles plus core latency.

## Test plan
- Single job: `req_valid[2]`=1, block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; model core returns done after 20 cycles with 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `req_ready`=0100 for one cycle, one `core_start` pulse, `rsp_valid`=0100, correct `rsp_data`, `rsp_err`=0.
- Round robin: all four `req_valid` held high for 8 jobs.
  - Grant order 0,1,2,3,0,1,2,3; each `rsp_valid` matches its grant.
- Timeout: TIMEOUT=64, core never asserts done.
  - `rsp_valid` 64 WAIT cycles after entering WAIT, `rsp_err`=1, `rsp_data`=0.
  - Next job proceeds normally.
- Done on the final timeout cycle (`timer`=63).
  - `rsp_err`=0 and `rsp_data`=`core_result`.
- Backpressure: hold `rsp_ready`=0 for 10 cycles while other `req_valid` lines are high.
  - `rsp_valid`/`rsp_data` stable, no `req_ready`, no `core_start`.
- Reset during WAIT, then a late `core_done`.
  - All outputs 0, no `rsp_valid`, `rr_ptr`=0.
  - The next request from requester 0 is granted first.
